// File: rtl/mux_nch_buf.sv
// N-channel selector feeding a small first-word-fall-through FIFO.
// Words from the channel chosen by select are buffered and presented downstream with backpressure.
module mux_nch_buf #(
    parameter int D_WIDTH = 8,
    parameter int N_CH    = 4,
    parameter int SEL_W   = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEL_W-1:0]           select,
    input  logic [N_CH*D_WIDTH-1:0]    data_i,
    input  logic [N_CH-1:0]            valid_i,
    output logic [N_CH-1:0]            ready_o,
    output logic [D_WIDTH-1:0]         data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       sel_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [D_WIDTH-1:0] ch_data [N_CH];

    logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]      rd_ptr_next;
    logic [LW-1:0]      level_reg, level_next, level_after_pop;
    logic [D_WIDTH-1:0] head_reg;
    logic               sel_err_reg;

    logic [D_WIDTH-1:0] sel_data;
    logic               sel_valid;
    logic               sel_in_range;
    logic               full;
    logic               push, pop;

    assign full         = (level_reg == LW'(DEPTH));
    assign sel_in_range = ({1'b0, select} < (SEL_W + 1)'(N_CH));

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_data[gi] = data_i[gi*D_WIDTH +: D_WIDTH];
            assign ready_o[gi] = (select == SEL_W'(gi)) && !full;
        end
    endgenerate

    // An out-of-range select matches no channel, so it never pushes.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (select == SEL_W'(k)) begin
                sel_data  = ch_data[k];
                sel_valid = valid_i[k];
            end
        end
    end

    assign valid_o = (level_reg != '0);
    assign push    = sel_valid && sel_in_range && !full;
    assign pop     = valid_o && ready_i;

    always_comb begin
        level_after_pop = level_reg - LW'(pop);
        level_next      = level_after_pop + LW'(push);
        rd_ptr_next     = rd_ptr_reg + PW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_reg] <= sel_data;
        end
    end

    // Head register: registered read of the new head, bypassing the incoming word
    // when the FIFO would otherwise be empty after this edge's pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            head_reg    <= '0;
            sel_err_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_reg + PW'(push);
            rd_ptr_reg  <= rd_ptr_next;
            level_reg   <= level_next;
            sel_err_reg <= !sel_in_range;
            if (level_next == '0) begin
                head_reg <= '0;
            end else if (push && (level_after_pop == '0)) begin
                head_reg <= sel_data;
            end else begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign data_o    = head_reg;
    assign level_o   = level_reg;
    assign sel_err_o = sel_err_reg;

endmodule

// File: tb/tb_mux_nch_buf.sv
// Randomized and directed bench for mux_nch_buf against a queue-based reference model.
module tb_mux_nch_buf;

    localparam int D_WIDTH = 8;
    localparam int N_CH    = 4;
    localparam int SEL_W   = 4;
    localparam int DEPTH   = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [SEL_W-1:0]        select;
    logic [N_CH*D_WIDTH-1:0] data_i;
    logic [N_CH-1:0]         valid_i;
    logic [N_CH-1:0]         ready_o;
    logic [D_WIDTH-1:0]      data_o;
    logic                    valid_o;
    logic                    ready_i;
    logic [$clog2(DEPTH):0]  level_o;
    logic                    sel_err_o;

    always #5 clk = ~clk;

    mux_nch_buf #(.D_WIDTH(D_WIDTH), .N_CH(N_CH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .select(select), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .level_o(level_o), .sel_err_o(sel_err_o)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    logic exp_err = 1'b0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] one_word(input int ch, input logic [7:0] w);
        logic [31:0] v;
        v = '0;
        v[ch*8 +: 8] = w;
        return v;
    endfunction

    // One clock: drive inputs, check ready_o, clock, update model, check outputs.
    task automatic cycle(input logic [3:0] sel, input logic [3:0] vld, input logic [31:0] dat,
                         input logic rdy, input logic r, output logic acc);
        logic [3:0] exp_rdy;
        logic       do_push, do_pop;
        rst = r; select = sel; valid_i = vld; data_i = dat; ready_i = rdy;
        #1;
        exp_rdy = (sel < N_CH && q.size() < DEPTH) ? (4'b0001 << sel) : 4'b0000;
        check("ready_o", 32'(ready_o), 32'(exp_rdy));
        do_push = !r && sel < N_CH && vld[sel] && q.size() < DEPTH;
        do_pop  = !r && q.size() > 0 && rdy;
        acc = do_push;
        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete();
            exp_err = 1'b0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(dat[sel*8 +: 8]);
            exp_err = (sel >= N_CH);
        end
        #1;
        check("valid_o", 32'(valid_o), 32'(q.size() > 0));
        check("data_o", 32'(data_o), (q.size() > 0) ? 32'(q[0]) : 32'h0);
        check("level_o", 32'(level_o), 32'(q.size()));
        check("sel_err_o", 32'(sel_err_o), 32'(exp_err));
        $display("cyc=%0d rst=%0b sel=%0d vld=%b rdy=%0b push=%0b pop=%0b -> data=%02h valid=%0b level=%0d err=%0b",
                 cyc, r, sel, vld, rdy, do_push, do_pop, data_o, valid_o, level_o, sel_err_o);
    endtask

    initial begin
        logic acc;
        int   idx;
        logic [7:0] w;

        rst = 1'b1; select = '0; valid_i = '0; data_i = '0; ready_i = 1'b0;
        @(posedge clk); #1;
        cycle(0, 0, 0, 0, 1, acc);
        check("reset_level", 32'(level_o), 0);
        check("reset_data", 32'(data_o), 0);

        // Back-to-back stream from channel 2 with downstream always ready.
        for (int i = 0; i < 3; i++) begin
            cycle(2, 4'b0100, one_word(2, 8'hA1 + 8'(i)), 1, 0, acc);
            check("tp1_data", 32'(data_o), 32'hA1 + 32'(i));
            check("tp1_level", 32'(level_o), 1);
        end
        cycle(2, 0, 0, 1, 0, acc);

        // Fill channel 0 while stalled, then release one pop, then drain.
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 4'b0001, one_word(0, 8'h10 + 8'(idx)), 0, 0, acc);
            if (acc) idx++;
        end
        check("full_level", 32'(level_o), 4);
        check("full_ready", 32'(ready_o), 0);
        cycle(0, 4'b0001, one_word(0, 8'h10 + 8'(idx)), 1, 0, acc);
        check("full_pop_level", 32'(level_o), 3);
        check("full_no_push", 32'(acc), 0);
        cycle(0, 4'b0001, one_word(0, 8'h10 + 8'(idx)), 0, 0, acc);
        if (acc) idx++;
        check("refill_level", 32'(level_o), 4);
        for (int i = 0; i < 12; i++) begin
            cycle(0, (idx < 8) ? 4'b0001 : 4'b0000, one_word(0, 8'h10 + 8'(idx)), 1, 0, acc);
            if (acc) idx++;
        end
        check("stream_done", 32'(idx), 8);

        // Two words from channel 1, then switch to channel 3.
        cycle(1, 4'b0010, one_word(1, 8'hB0), 0, 0, acc);
        cycle(1, 4'b0010, one_word(1, 8'hB1), 0, 0, acc);
        cycle(3, 4'b1010, one_word(3, 8'hC0) | one_word(1, 8'hB2), 0, 0, acc);
        check("switch_head", 32'(data_o), 32'hB0);
        for (int i = 0; i < 3; i++) begin
            w = data_o;
            cycle(3, 4'b0010, one_word(1, 8'hB2), 1, 0, acc);
            check("switch_order", 32'(w), (i == 0) ? 32'hB0 : (i == 1) ? 32'hB1 : 32'hC0);
        end

        // Out-of-range select with everything valid; buffered words keep draining.
        cycle(1, 4'b0010, one_word(1, 8'hD0), 0, 0, acc);
        cycle(1, 4'b0010, one_word(1, 8'hD1), 0, 0, acc);
        cycle(4, 4'b1111, 32'hFFFFFFFF, 1, 0, acc);
        check("oor_err1", 32'(sel_err_o), 1);
        cycle(4, 4'b1111, 32'hFFFFFFFF, 1, 0, acc);
        check("oor_err2", 32'(sel_err_o), 1);
        check("oor_level", 32'(level_o), 0);
        cycle(1, 4'b0000, 0, 1, 0, acc);
        check("oor_err_clear", 32'(sel_err_o), 0);

        // Reset with three words buffered, then a fresh word.
        for (int i = 0; i < 3; i++) cycle(2, 4'b0100, one_word(2, 8'hE0 + 8'(i)), 0, 0, acc);
        check("pre_rst_level", 32'(level_o), 3);
        cycle(2, 4'b0100, one_word(2, 8'hEE), 1, 1, acc);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_data", 32'(data_o), 0);
        cycle(2, 4'b0100, one_word(2, 8'h55), 1, 0, acc);
        check("post_rst_data", 32'(data_o), 32'h55);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 5)), 4'($urandom), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0), acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
